// File: rtl/usb_stream_in_pkg.sv
// Shared definitions for the usb_stream_in bulk IN source: handshake codes
// (common with usb_ep and main) and the transfer state encoding.
package usb_stream_in_pkg;

    localparam logic [1:0] hs_ack   = 2'b00;
    localparam logic [1:0] hs_none  = 2'b01;
    localparam logic [1:0] hs_nak   = 2'b10;
    localparam logic [1:0] hs_stall = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } xfer_state_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// Byte FIFO storage for usb_stream_in: 2**DEPTH_LOG2 x 8 RAM with one
// 16-bit write port (low byte at waddr, high byte at waddr+1) and one
// asynchronous 8-bit read port.
module stream_fifo_mem #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [15:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0]            mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] waddr_hi;

    assign waddr_hi = waddr + DEPTH_LOG2'(1);

    // Store both bytes of a sample word; the second address wraps naturally.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]    <= wdata[7:0];
            mem[waddr_hi] <= wdata[15:8];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_stream_in.sv
// usb_stream_in: buffers 16-bit samples and serves them as bytes to a bulk
// IN endpoint. Bytes are read speculatively and only committed when the host
// acknowledges, so NAKed or corrupted packets are replayed.
// Optional feature: define USB_STREAM_ZLP_EN to send a zero-length packet
// after a full-size packet that empties the FIFO.
module usb_stream_in
    import usb_stream_in_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_PACKET = 64
) (
    input  logic                  clk_48,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [15:0]           sample,
    input  logic                  sample_valid,
    input  logic                  usb_rst,
    input  logic                  ep_sel,
    input  logic                  transaction_active,
    input  logic                  direction_in,
    input  logic                  setup,
    input  logic                  data_strobe,
    input  logic                  success,
    output logic [7:0]            data_in,
    output logic                  data_in_valid,
    output logic [1:0]            handshake,
    output logic                  toggle,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int AW = DEPTH_LOG2 + 1;
    localparam int PW = $clog2(MAX_PACKET + 1);
    localparam logic [AW-1:0] DEPTH_L = AW'(2**DEPTH_LOG2);
    localparam logic [AW-1:0] MAXP_L  = AW'(MAX_PACKET);
    localparam logic [PW-1:0] MAXP_P  = PW'(MAX_PACKET);

    xfer_state_t   state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] spec_ptr;
    logic [PW-1:0] pkt_len;
    logic [PW-1:0] sent;
    logic          ta_d;
    logic          toggle_q;
    logic          overflow_q;
    logic          dv_q;

    logic [AW-1:0] level_c;
    logic [AW-1:0] rptr_next;
    logic [PW-1:0] len_c;
    logic          wr_ok;
    logic          in_start;
    logic          strobe_ok;
    logic          commit;
    logic          empty_c;

`ifdef USB_STREAM_ZLP_EN
    logic          zlp_pending;
`endif

    assign level_c   = wptr - rptr;
    assign wr_ok     = sample_valid && enable && (level_c <= DEPTH_L - AW'(2));
    assign in_start  = transaction_active && !ta_d && ep_sel && direction_in && !setup;
    assign strobe_ok = (state == ST_XFER) && data_strobe && (sent < pkt_len);
    assign commit    = (state == ST_XFER) && success && !usb_rst;
    assign rptr_next = commit ? spec_ptr : rptr;
    assign len_c     = (level_c >= MAXP_L) ? MAXP_P : PW'(level_c);

    stream_fifo_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk   (clk_48),
        .we    (wr_ok),
        .waddr (wptr[DEPTH_LOG2-1:0]),
        .wdata (sample),
        .raddr (spec_ptr[DEPTH_LOG2-1:0]),
        .rdata (data_in)
    );

    // Write side: accept two bytes per sample, drop on full, flush on disable.
    // The flush targets the post-commit read pointer so a commit landing in
    // the same cycle cannot leave rptr ahead of wptr.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            overflow_q <= 1'b0;
        end else if (!enable) begin
            wptr       <= rptr_next;
            overflow_q <= 1'b0;
        end else if (sample_valid) begin
            if (wr_ok) begin
                wptr <= wptr + AW'(2);
            end else begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transfer FSM: speculative read pointer, commit on success, replay otherwise.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rptr     <= '0;
            spec_ptr <= '0;
            pkt_len  <= '0;
            sent     <= '0;
            ta_d     <= 1'b0;
            toggle_q <= 1'b0;
            dv_q     <= 1'b0;
`ifdef USB_STREAM_ZLP_EN
            zlp_pending <= 1'b0;
`endif
        end else begin
            ta_d <= transaction_active;
            if (usb_rst) begin
                state    <= ST_IDLE;
                toggle_q <= 1'b0;
                spec_ptr <= rptr;
                sent     <= '0;
                dv_q     <= 1'b0;
`ifdef USB_STREAM_ZLP_EN
                zlp_pending <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_start) begin
                            state    <= ST_XFER;
                            pkt_len  <= len_c;
                            sent     <= '0;
                            spec_ptr <= rptr;
                            dv_q     <= (len_c != '0);
                        end
                    end
                    ST_XFER: begin
                        if (success) begin
                            state    <= ST_IDLE;
                            rptr     <= spec_ptr;
                            toggle_q <= ~toggle_q;
                            dv_q     <= 1'b0;
`ifdef USB_STREAM_ZLP_EN
                            zlp_pending <= (sent == MAXP_P) && (level_c == AW'(sent));
`endif
                        end else if (!transaction_active) begin
                            state    <= ST_IDLE;
                            spec_ptr <= rptr;
                            dv_q     <= 1'b0;
                        end else if (strobe_ok) begin
                            sent     <= sent + PW'(1);
                            spec_ptr <= spec_ptr + AW'(1);
                            dv_q     <= ((sent + PW'(1)) < pkt_len);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
`ifdef USB_STREAM_ZLP_EN
                if (!enable) begin
                    zlp_pending <= 1'b0;
                end
`endif
            end
        end
    end

    // Handshake: stall non-IN traffic, nak when nothing to send, else ack.
    always_comb begin
`ifdef USB_STREAM_ZLP_EN
        empty_c = ((state == ST_XFER) ? (pkt_len == '0) : (level_c == '0)) && !zlp_pending;
`else
        empty_c = (state == ST_XFER) ? (pkt_len == '0) : (level_c == '0);
`endif
        handshake = hs_ack;
        if (ep_sel && (setup || !direction_in)) begin
            handshake = hs_stall;
        end else if (empty_c) begin
            handshake = hs_nak;
        end
    end

    assign data_in_valid = dv_q;
    assign toggle        = toggle_q;
    assign level         = level_c;
    assign overflow      = overflow_q;

endmodule
